// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch front end with a one-entry skid buffer.
// Issues sequential requests to instruction memory, delivers each word with
// its PC+2 to decode, holds under stall, handles redirects (including one that
// lands while a memory request is still outstanding) and stops after HALT.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   stall           decode stall; output register holds
//   redirect        taken branch/jump/return, target on redirectPc
//   imemData/Done   instruction memory response
//   imemAddr/En     instruction memory request (address is the PC register)
//   instrOut, nextPcOut, validOut   decode-side output register
//   halted          fetch stopped after a HALT
//   err             sticky misaligned-redirect flag
module fetch_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirectPc,
  input  logic [15:0] imemData,
  input  logic        imemDone,
  output logic [15:0] imemAddr,
  output logic        imemEn,
  output logic [15:0] instrOut,
  output logic [15:0] nextPcOut,
  output logic        validOut,
  output logic        halted,
  output logic        err
);

  localparam int unsigned XLEN = 16;
  localparam logic [XLEN-1:0] NOP = 16'h0800;

  typedef enum logic [1:0] {FETCH, WAIT, DRAIN, HALTED} state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] npc;
  } slot_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] target;
  logic            skid_full;
  slot_t           skid;

  logic            issue;
  logic            fire;
  logic            accept;
  logic            is_halt;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] redirect_pc_aligned;

  // Request/handshake decode from the registered state.
  always_comb begin
    issue               = 1'b0;
    fire                = 1'b0;
    accept              = 1'b0;
    is_halt             = 1'b0;
    pc_inc              = pc + XLEN'(2);
    redirect_pc_aligned = {redirectPc[XLEN-1:1], 1'b0};
    // No request while the skid buffer is occupied.
    issue   = rst && ((state == WAIT) || (state == DRAIN) ||
                      ((state == FETCH) && !skid_full));
    fire    = issue && imemDone;
    accept  = fire && !redirect && ((state == FETCH) || (state == WAIT));
    is_halt = (imemData[15:11] == 5'b00000);
  end

  assign imemEn   = issue;
  assign imemAddr = pc;
  assign halted   = (state == HALTED);

  // Control FSM, PC, output register and skid buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FETCH;
      pc        <= '0;
      target    <= '0;
      skid_full <= 1'b0;
      skid      <= '0;
      instrOut  <= NOP;
      nextPcOut <= '0;
      validOut  <= 1'b0;
      err       <= 1'b0;
    end else if (redirect) begin
      err       <= err | redirectPc[0];
      validOut  <= 1'b0;
      instrOut  <= NOP;
      skid_full <= 1'b0;
      // A request still in flight must finish at its old address before the
      // new PC is presented; the target is parked until then.
      if (issue && !imemDone) begin
        state  <= DRAIN;
        target <= redirect_pc_aligned;
      end else begin
        state <= FETCH;
        pc    <= redirect_pc_aligned;
      end
    end else begin
      // Output register: hold only when it carries a real instruction.
      if (!stall || !validOut) begin
        if (skid_full) begin
          instrOut  <= skid.instr;
          nextPcOut <= skid.npc;
          validOut  <= 1'b1;
          skid_full <= 1'b0;
        end else if (accept) begin
          instrOut  <= imemData;
          nextPcOut <= pc_inc;
          validOut  <= 1'b1;
        end else begin
          instrOut  <= NOP;
          validOut  <= 1'b0;
        end
      end else if (accept) begin
        skid      <= '{instr: imemData, npc: pc_inc};
        skid_full <= 1'b1;
      end

      case (state)
        FETCH, WAIT: begin
          if (accept) begin
            pc    <= pc_inc;
            state <= is_halt ? HALTED : FETCH;
          end else if (issue) begin
            state <= WAIT;
          end
        end
        DRAIN: begin
          // Late word is dropped; resume at the parked redirect target.
          if (fire) begin
            pc    <= target;
            state <= FETCH;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule
